// File: rtl/dds_reg_pkg.sv
// dds_reg_pkg: register map constants, CTRL layout and byte-strobe helper
// shared by the DDS multi-channel register bank.
package dds_reg_pkg;

  // Word offsets inside one channel's 16-byte window
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_DATA = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;

  // CTRL bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_SRST    = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_IRQ_MSK = 3;

  // STAT bit indices
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  // Byte distance between consecutive channel windows
  localparam int CH_STRIDE = 16;

  // Data returned for unmapped reads
  localparam logic [31:0] RD_ERR_DATA = 32'h0;

  // Stored CTRL image; srst/start are command bits and always hold 0
  typedef struct packed {
    logic irq_msk;
    logic start;
    logic srst;
    logic en;
  } ctrl_t;

  // Merge write data into an existing word under byte enables
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] w;
    w = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dds_reg_bank_if.sv
// dds_reg_bank_if: registered rd/wr port between the bus-slave front end
// (master) and the DDS register bank (slave).
interface dds_reg_bank_if #(
  parameter int ADDR_W = 8
);
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [31:0]       i_wr_data;
  logic [3:0]        i_wr_strb;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [31:0]       o_rd_data;
  logic              o_rd_valid;
  logic              o_rd_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_strb, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_rd_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_strb, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid, o_rd_err
  );
endinterface

// File: rtl/dds_reg_channel.sv
// dds_reg_channel: one channel's CTRL/DATA/STAT registers, command pulse
// generation, sticky status and the channel's interrupt source.
module dds_reg_channel
  import dds_reg_pkg::*;
#(
  parameter int SIG_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_ctrl,
  input  logic                        wr_data,
  input  logic                        wr_stat,
  input  logic [31:0]                 wdata,
  input  logic [3:0]                  strb,
  input  logic                        busy,
  input  logic                        done,
  input  logic                        ovf,
  output logic                        ch_en,
  output logic                        ch_rst,
  output logic                        ch_start,
  output logic                        ch_data_wr,
  output logic signed [SIG_WIDTH-1:0] ch_data,
  output logic                        irq_src,
  output logic [31:0]                 ctrl_rd,
  output logic [31:0]                 data_rd,
  output logic [31:0]                 stat_rd
);

  ctrl_t       ctrl_q;
  logic [31:0] data_q;
  logic        done_q;
  logic        ovf_q;
  logic        ctrl_wr;
  logic        stat_wr;

  // CTRL bits all live in byte 0
  assign ctrl_wr = wr_ctrl & strb[0];
  assign stat_wr = wr_stat & strb[0];

  // CTRL storage and one-cycle SRST/START command pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      ch_rst   <= 1'b0;
      ch_start <= 1'b0;
    end else begin
      ch_rst         <= ctrl_wr & wdata[CTRL_SRST];
      ch_start       <= ctrl_wr & wdata[CTRL_START];
      ctrl_q.srst    <= 1'b0;
      ctrl_q.start   <= 1'b0;
      if (ctrl_wr) begin
        ctrl_q.en      <= wdata[CTRL_EN];
        ctrl_q.irq_msk <= wdata[CTRL_IRQ_MSK];
      end
    end
  end

  // DATA word: byte-strobed write, cleared while the soft-reset pulse is out
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      ch_data_wr <= 1'b0;
    end else begin
      ch_data_wr <= wr_data & (|strb);
      if (ch_rst) data_q <= '0;
      else if (wr_data) data_q <= apply_strb(data_q, wdata, strb);
    end
  end

  // Sticky DONE/OVF: W1C and soft reset clear, a coincident event wins
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= (done_q & ~(ch_rst | (stat_wr & wdata[STAT_DONE]))) | done;
      ovf_q  <= (ovf_q  & ~(ch_rst | (stat_wr & wdata[STAT_OVF])))  | ovf;
    end
  end

  // Read-back images and datapath-facing views
  always_comb begin
    stat_rd            = '0;
    stat_rd[STAT_BUSY] = busy;
    stat_rd[STAT_DONE] = done_q;
    stat_rd[STAT_OVF]  = ovf_q;
  end

  assign ctrl_rd = {28'h0, ctrl_q};
  assign data_rd = data_q;
  assign ch_en   = ctrl_q.en;
  assign ch_data = data_q[SIG_WIDTH-1:0];
  assign irq_src = (done_q | ovf_q) & ~ctrl_q.irq_msk;

endmodule

// File: rtl/dds_reg_bank.sv
// dds_reg_bank: multi-channel DDS control/status register bank. Decodes the
// bus address into per-channel strobes, muxes a registered read response and
// combines channel interrupt sources. Build option DDS_IRQ_EN enables o_irq;
// without it o_irq is tied low (IRQ_MSK is still stored and readable).
module dds_reg_bank
  import dds_reg_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SIG_WIDTH = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  dds_reg_bank_if.slave                 bus,
  input  logic [NUM_CH-1:0]             i_busy,
  input  logic [NUM_CH-1:0]             i_done,
  input  logic [NUM_CH-1:0]             i_ovf,
  output logic [NUM_CH-1:0]             o_ch_en,
  output logic [NUM_CH-1:0]             o_ch_rst,
  output logic [NUM_CH-1:0]             o_ch_start,
  output logic [NUM_CH*SIG_WIDTH-1:0]   o_ch_data,
  output logic [NUM_CH-1:0]             o_ch_data_wr,
  output logic                          o_irq
);

  localparam int CH_LSB = $clog2(CH_STRIDE);
  localparam int CH_W   = ADDR_W - CH_LSB;

  logic [CH_W-1:0] wr_ch;
  logic [CH_W-1:0] rd_ch;
  logic [1:0]      wr_off;
  logic [1:0]      rd_off;
  logic            rd_mapped;
  logic [31:0]     rd_val;

  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_data;
  logic [NUM_CH-1:0] wr_stat;
  logic [NUM_CH-1:0] irq_src;
  logic [31:0]       ctrl_rd [NUM_CH];
  logic [31:0]       data_rd [NUM_CH];
  logic [31:0]       stat_rd [NUM_CH];
  logic signed [SIG_WIDTH-1:0] ch_data [NUM_CH];

  assign wr_ch  = bus.i_wr_addr[ADDR_W-1:CH_LSB];
  assign wr_off = bus.i_wr_addr[CH_LSB-1:2];
  assign rd_ch  = bus.i_rd_addr[ADDR_W-1:CH_LSB];
  assign rd_off = bus.i_rd_addr[CH_LSB-1:2];

  assign rd_mapped = (32'(rd_ch) < 32'(NUM_CH)) && (rd_off != 2'd3);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit        = bus.i_wr_en && (wr_ch == CH_W'(c));
    assign wr_ctrl[c] = hit && (wr_off == OFF_CTRL);
    assign wr_data[c] = hit && (wr_off == OFF_DATA);
    assign wr_stat[c] = hit && (wr_off == OFF_STAT);

    dds_reg_channel #(.SIG_WIDTH(SIG_WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_ctrl    (wr_ctrl[c]),
      .wr_data    (wr_data[c]),
      .wr_stat    (wr_stat[c]),
      .wdata      (bus.i_wr_data),
      .strb       (bus.i_wr_strb),
      .busy       (i_busy[c]),
      .done       (i_done[c]),
      .ovf        (i_ovf[c]),
      .ch_en      (o_ch_en[c]),
      .ch_rst     (o_ch_rst[c]),
      .ch_start   (o_ch_start[c]),
      .ch_data_wr (o_ch_data_wr[c]),
      .ch_data    (ch_data[c]),
      .irq_src    (irq_src[c]),
      .ctrl_rd    (ctrl_rd[c]),
      .data_rd    (data_rd[c]),
      .stat_rd    (stat_rd[c])
    );

    assign o_ch_data[c*SIG_WIDTH +: SIG_WIDTH] = ch_data[c];
  end

  // Read mux over current register values (a same-cycle write is not yet visible)
  always_comb begin
    rd_val = RD_ERR_DATA;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        case (rd_off)
          OFF_CTRL: rd_val = ctrl_rd[c];
          OFF_DATA: rd_val = data_rd[c];
          OFF_STAT: rd_val = stat_rd[c];
          default:  rd_val = RD_ERR_DATA;
        endcase
      end
    end
  end

  // Registered read response, one cycle after the request
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_rd_valid <= 1'b0;
      bus.o_rd_err   <= 1'b0;
      bus.o_rd_data  <= '0;
    end else begin
      bus.o_rd_valid <= bus.i_rd_en;
      bus.o_rd_err   <= bus.i_rd_en & ~rd_mapped;
      bus.o_rd_data  <= (bus.i_rd_en && rd_mapped) ? rd_val : RD_ERR_DATA;
    end
  end

`ifdef DDS_IRQ_EN
  logic unused_bits;
  assign unused_bits = ^{bus.i_wr_addr[1:0], bus.i_rd_addr[1:0]};

  // Interrupt: any unmasked sticky source, registered
  always_ff @(posedge clk) begin
    if (rst) o_irq <= 1'b0;
    else     o_irq <= |irq_src;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bus.i_wr_addr[1:0], bus.i_rd_addr[1:0], irq_src};
  assign o_irq = 1'b0;
`endif

endmodule
